// File: rtl/sco_pkg.sv
// Shared stopwatch definitions: key channel indices, debounce FSM states and
// millisecond-to-cycle conversion helpers.
package sco_pkg;

   localparam int unsigned KEY_BS  = 0;
   localparam int unsigned KEY_REC = 1;
   localparam int unsigned KEY_DIS = 2;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } kstate_t;

   function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stable-time counter and
// press/release FSM. Hold-to-repeat strobes are enabled by KEY_REPEAT_EN.
module key_debounce_ch
   import sco_pkg::*;
#(
   parameter int unsigned DB = 4,
   parameter int unsigned RD = 10,
   parameter int unsigned RP = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic pulse,
   output logic level
);

`ifdef KEY_REPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   localparam int unsigned CW   = cnt_width(DB);
   localparam int unsigned RMAX = (RD > RP) ? RD : RP;
   localparam int unsigned RW   = cnt_width(RMAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);
   localparam logic [RW-1:0] RD_LAST  = RW'(RD - 1);
   localparam logic [RW-1:0] RP_LAST  = RW'(RP - 1);

   logic          s1, s2, pressed;
   kstate_t       state, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [RW-1:0] rcnt;
   logic          rep, rpt_fire;
   logic          pulse_nxt, level_nxt;

   assign pressed = ~s2;

   // rcnt counts only while staying in HELD; any entry or exit restarts it.
   assign rpt_fire = REPEAT_ON && (state == HELD) && pressed &&
                     (rcnt == (rep ? RP_LAST : RD_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
         rcnt  <= '0;
         rep   <= 1'b0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         s1    <= key_raw;
         s2    <= s1;
         state <= nxt;
         cnt   <= cnt_nxt;
         pulse <= pulse_nxt;
         level <= level_nxt;
         if (state != HELD || nxt != HELD) begin
            rcnt <= '0;
            rep  <= 1'b0;
         end else if (rpt_fire) begin
            rcnt <= '0;
            rep  <= 1'b1;
         end else begin
            rcnt <= rcnt + RW'(1);
         end
      end
   end

   always_comb begin
      nxt       = state;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (pressed) begin
               nxt     = PRESS_WAIT;
               cnt_nxt = '0;
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               nxt       = HELD;
               pulse_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HELD: begin
            if (!pressed) begin
               nxt     = RELEASE_WAIT;
               cnt_nxt = '0;
            end else if (rpt_fire) begin
               pulse_nxt = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (pressed) begin
               nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      level_nxt = (nxt == HELD) || (nxt == RELEASE_WAIT);
   end

endmodule

// File: rtl/key_debounce.sv
// Debounces the raw active-low push-buttons into one-cycle press strobes and
// pressed levels for the stopwatch core. Optional repeat: KEY_REPEAT_EN.
module key_debounce
   import sco_pkg::*;
#(
   parameter int unsigned N_KEYS           = 3,
   parameter int unsigned CLK_HZ           = 50_000_000,
   parameter int unsigned DEBOUNCE_MS      = 20,
   parameter int unsigned REPEAT_DELAY_MS  = 500,
   parameter int unsigned REPEAT_PERIOD_MS = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_pulse,
   output logic [N_KEYS-1:0] key_level
);

   localparam int unsigned DB = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned RD = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
   localparam int unsigned RP = ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DB(DB),
         .RD(RD),
         .RP(RP)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .key_raw(key_in[i]),
         .pulse  (key_pulse[i]),
         .level  (key_level[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce with DB=4 cycles, repeat
// delay 10 cycles and repeat period 5 cycles.
module tb_key_debounce;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] key_in;
   logic [2:0] key_pulse;
   logic [2:0] key_level;

   int unsigned tests  = 0;
   int unsigned failed = 0;

   key_debounce #(
      .N_KEYS          (3),
      .CLK_HZ          (1000),
      .DEBOUNCE_MS     (4),
      .REPEAT_DELAY_MS (10),
      .REPEAT_PERIOD_MS(5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .key_pulse(key_pulse),
      .key_level(key_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs n edges; pulse expected to equal pmask only after edge pt,
   // level equals lv_pre before edge lt and lv_post from edge lt on.
   task automatic watch(input string tag, input int n, input int pt,
                        input logic [2:0] pmask, input logic [2:0] lv_pre,
                        input logic [2:0] lv_post, input int lt);
      for (int i = 1; i <= n; i++) begin
         tick();
         check($sformatf("%s pulse@%0d", tag, i), 32'(key_pulse),
               32'((i == pt) ? pmask : 3'b000));
         check($sformatf("%s level@%0d", tag, i), 32'(key_level),
               32'((i >= lt) ? lv_post : lv_pre));
      end
   endtask

   initial begin
      rst    = 1'b1;
      key_in = 3'b111;
      tick();
      tick();
      check("reset pulse", 32'(key_pulse), 32'h0);
      check("reset level", 32'(key_level), 32'h0);
      rst = 1'b0;
      watch("idle", 3, 0, 3'b000, 3'b000, 3'b000, 99);

      // clean press on bs: pulse after 7th edge (k+DB+2)
      key_in[0] = 1'b0;
      watch("press0", 10, 7, 3'b001, 3'b000, 3'b001, 7);

      // bounce on rec: low 3, high 1, then low and hold
      key_in[1] = 1'b0;
      watch("bounce_lo", 3, 0, 3'b000, 3'b001, 3'b001, 99);
      key_in[1] = 1'b1;
      watch("bounce_hi", 1, 0, 3'b000, 3'b001, 3'b001, 99);
      key_in[1] = 1'b0;
      watch("bounce_hold", 10, 7, 3'b010, 3'b001, 3'b011, 7);

      // releases: level falls after 7th edge, never a pulse
      key_in[0] = 1'b1;
      watch("release0", 9, 0, 3'b000, 3'b011, 3'b010, 7);
      key_in[1] = 1'b1;
      watch("release1", 9, 0, 3'b000, 3'b010, 3'b000, 7);

      // 2-cycle glitch on dis
      key_in[2] = 1'b0;
      watch("glitch_lo", 2, 0, 3'b000, 3'b000, 3'b000, 99);
      key_in[2] = 1'b1;
      watch("glitch_hi", 10, 0, 3'b000, 3'b000, 3'b000, 99);

      // simultaneous press
      key_in = 3'b000;
      watch("simul", 9, 7, 3'b111, 3'b000, 3'b111, 7);
      key_in = 3'b111;
      watch("simul_rel", 9, 0, 3'b000, 3'b111, 3'b000, 7);

      // reset during PRESS_WAIT, key kept held through reset
      key_in[0] = 1'b0;
      watch("rst_pw", 4, 0, 3'b000, 3'b000, 3'b000, 99);
      rst = 1'b1;
      watch("rst_on", 3, 0, 3'b000, 3'b000, 3'b000, 99);
      rst = 1'b0;
      watch("rst_held", 9, 7, 3'b001, 3'b000, 3'b001, 7);

      // reset while held aborts the level
      rst    = 1'b1;
      key_in = 3'b111;
      watch("rst_hold", 2, 0, 3'b000, 3'b000, 3'b000, 99);
      rst = 1'b0;
      watch("rst_after", 5, 0, 3'b000, 3'b000, 3'b000, 99);

      // long hold on dis
      key_in[2] = 1'b0;
      for (int i = 1; i <= 35; i++) begin
         logic rep_hit;
         tick();
`ifdef KEY_REPEAT_EN
         rep_hit = (i == 7) || (i == 17) || (i == 22) || (i == 27) || (i == 32);
`else
         rep_hit = (i == 7);
`endif
         check($sformatf("hold2 pulse@%0d", i), 32'(key_pulse),
               32'(rep_hit ? 3'b100 : 3'b000));
         check($sformatf("hold2 level@%0d", i), 32'(key_level),
               32'((i >= 7) ? 3'b100 : 3'b000));
      end
      key_in[2] = 1'b1;
      watch("hold2_rel", 9, 0, 3'b000, 3'b100, 3'b000, 7);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
